// File: rtl/simd_regfile_pkg.sv
// Shared constants, clear-engine state type and address-width helper for the
// per-lane SIMD register file.
package simd_regfile_pkg;

  localparam int LANES_DEF  = 8;
  localparam int DEPTH_DEF  = 16;
  localparam int WIDTH_DEF  = 64;
  localparam int RPORTS_DEF = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Address bits needed to index 'depth' registers (at least one bit).
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/simd_regfile_lane.sv
// One lane of the register file: storage, one write port and RPORTS
// registered read ports with optional write-to-read forwarding.
// Write inputs arrive already muxed with the clear engine and range-checked.
module regfile_lane
  import simd_regfile_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int RPORTS = RPORTS_DEF,
  parameter int BYPASS = 1,
  parameter int AW     = addr_w(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           we,
  input  logic [AW-1:0]                  waddr,
  input  logic [WIDTH-1:0]               wdata,
  input  logic [RPORTS-1:0]              re,
  input  logic [RPORTS-1:0][AW-1:0]      raddr,
  input  logic [RPORTS-1:0]              raddr_ok,
  input  logic                           rd_allow,
  output logic [RPORTS-1:0][WIDTH-1:0]   rdata,
  output logic [RPORTS-1:0]              rvalid
);

  logic [WIDTH-1:0]             mem [DEPTH];
  logic [RPORTS-1:0][WIDTH-1:0] rdata_q, rdata_d;
  logic [RPORTS-1:0]            rvalid_q, rvalid_d;

  // Storage write; contents are zeroed by the clear engine, not by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read selection: out-of-range reads return zero, same-address writes
  // are forwarded when BYPASS is set, unread ports hold their data.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = '0;
    for (int p = 0; p < RPORTS; p++) begin
      if (re[p]) begin
        rvalid_d[p] = rd_allow;
        if (!raddr_ok[p]) begin
          rdata_d[p] = '0;
        end else if ((BYPASS != 0) && we && (waddr == raddr[p])) begin
          rdata_d[p] = wdata;
        end else begin
          rdata_d[p] = mem[raddr[p]];
        end
      end
    end
  end

  // Registered read outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

// File: rtl/simd_regfile.sv
// Parametrised per-lane SIMD register file. Holds the clear engine that
// zeroes every entry after reset or on request, the write/clear mux, the
// address range checks and the dropped-write pulse. init_busy is the clear
// FSM state made visible (high exactly while in CLEAR).
module simd_regfile
  import simd_regfile_pkg::*;
#(
  parameter  int LANES  = LANES_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  parameter  int WIDTH  = WIDTH_DEF,
  parameter  int RPORTS = RPORTS_DEF,
  parameter  int BYPASS = 1,
  localparam int AW     = addr_w(DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  clear_req,
  input  logic [LANES-1:0]                      write_en,
  input  logic [AW-1:0]                         waddr,
  input  logic [LANES-1:0][WIDTH-1:0]           wdata,
  input  logic [RPORTS-1:0][LANES-1:0]          read_en,
  input  logic [RPORTS-1:0][AW-1:0]             raddr,
  output logic [RPORTS-1:0][LANES-1:0][WIDTH-1:0] rdata,
  output logic [RPORTS-1:0][LANES-1:0]          rvalid,
  output logic                                  init_busy,
  output logic                                  wr_drop
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);

  clr_state_e                  state_q, state_d;
  logic [AW-1:0]               clr_addr_q, clr_addr_d;
  logic                        wr_drop_q, wr_drop_d;
  logic                        busy;
  logic                        waddr_ok;
  logic [RPORTS-1:0]           raddr_ok;
  logic [LANES-1:0]            eff_we;
  logic [AW-1:0]               eff_addr;
  logic [LANES-1:0][WIDTH-1:0] eff_wdata;

  // Clear FSM next state: walk 0..DEPTH-1 once, requests during a walk ignored.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      CLEAR: begin
        if (clr_addr_q == LAST_A) begin
          state_d    = IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + AW'(1);
        end
      end
      default: begin
        state_d    = CLEAR;
        clr_addr_d = '0;
      end
    endcase
  end

  // Range checks, clear/write mux and dropped-write detection.
  always_comb begin
    busy      = (state_q == CLEAR);
    waddr_ok  = ({1'b0, waddr} < DEPTH_C);
    raddr_ok  = '0;
    eff_we    = '0;
    eff_wdata = '0;
    for (int p = 0; p < RPORTS; p++) begin
      raddr_ok[p] = ({1'b0, raddr[p]} < DEPTH_C);
    end
    eff_addr = busy ? clr_addr_q : waddr;
    for (int l = 0; l < LANES; l++) begin
      eff_we[l]    = busy | (write_en[l] & waddr_ok);
      eff_wdata[l] = busy ? '0 : wdata[l];
    end
    wr_drop_d = (|write_en) & (busy | ~waddr_ok);
  end

  // Clear FSM, walk address and drop pulse registers; reset starts a walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      wr_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      wr_drop_q  <= wr_drop_d;
    end
  end

  assign init_busy = busy;
  assign wr_drop   = wr_drop_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [RPORTS-1:0][WIDTH-1:0] lane_rdata;
    logic [RPORTS-1:0]            lane_rvalid;
    logic [RPORTS-1:0]            lane_re;

    for (genvar p = 0; p < RPORTS; p++) begin : g_port
      assign lane_re[p]   = read_en[p][l];
      assign rdata[p][l]  = lane_rdata[p];
      assign rvalid[p][l] = lane_rvalid[p];
    end

    regfile_lane #(
      .DEPTH  (DEPTH),
      .WIDTH  (WIDTH),
      .RPORTS (RPORTS),
      .BYPASS (BYPASS),
      .AW     (AW)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (eff_we[l]),
      .waddr    (eff_addr),
      .wdata    (eff_wdata[l]),
      .re       (lane_re),
      .raddr    (raddr),
      .raddr_ok (raddr_ok),
      .rd_allow (~busy),
      .rdata    (lane_rdata),
      .rvalid   (lane_rvalid)
    );
  end

endmodule

// File: tb/tb_simd_regfile.sv
// Bench for simd_regfile: three instances (DEPTH 16 BYPASS 1, DEPTH 16
// BYPASS 0, DEPTH 12 BYPASS 1) share one directed stimulus stream. A
// register-file model per instance predicts all outputs every cycle, and
// literal expectations pin key values.
module tb_simd_regfile;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  clear_req;
  logic [7:0]            write_en;
  logic [3:0]            waddr;
  logic [7:0][63:0]      wdata;
  logic [1:0][7:0]       read_en;
  logic [1:0][3:0]       raddr;
  logic [1:0][7:0][63:0] rdata_o [3];
  logic [1:0][7:0]       rvalid_o [3];
  logic                  busy_o [3];
  logic                  drop_o [3];

  int tests = 0;
  int fails = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  simd_regfile #(.LANES(8), .DEPTH(16), .WIDTH(64), .RPORTS(2), .BYPASS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .write_en(write_en),
    .waddr(waddr), .wdata(wdata), .read_en(read_en), .raddr(raddr),
    .rdata(rdata_o[0]), .rvalid(rvalid_o[0]), .init_busy(busy_o[0]), .wr_drop(drop_o[0]));

  simd_regfile #(.LANES(8), .DEPTH(16), .WIDTH(64), .RPORTS(2), .BYPASS(0)) u1 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .write_en(write_en),
    .waddr(waddr), .wdata(wdata), .read_en(read_en), .raddr(raddr),
    .rdata(rdata_o[1]), .rvalid(rvalid_o[1]), .init_busy(busy_o[1]), .wr_drop(drop_o[1]));

  simd_regfile #(.LANES(8), .DEPTH(12), .WIDTH(64), .RPORTS(2), .BYPASS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .write_en(write_en),
    .waddr(waddr), .wdata(wdata), .read_en(read_en), .raddr(raddr),
    .rdata(rdata_o[2]), .rvalid(rvalid_o[2]), .init_busy(busy_o[2]), .wr_drop(drop_o[2]));

  // ---------------- model ----------------
  int                    dep [3] = '{16, 16, 12};
  bit                    byp [3] = '{1'b1, 1'b0, 1'b1};
  logic [63:0]           mmem [3][8][16];
  int                    left [3];
  logic [1:0][7:0][63:0] exp_rdata [3];
  logic [1:0][7:0]       exp_rvalid [3];
  logic                  exp_drop [3];
  bit                    model_live = 1'b0;
  bit                    m_busy, m_wok;
  int                    m_caddr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        left[i]       = dep[i];
        exp_rdata[i]  = '0;
        exp_rvalid[i] = '0;
        exp_drop[i]   = 1'b0;
      end
      model_live = 1'b1;
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_busy  = (left[i] > 0);
        m_wok   = (int'(waddr) < dep[i]);
        m_caddr = dep[i] - left[i];
        for (int p = 0; p < 2; p++) begin
          for (int l = 0; l < 8; l++) begin
            if (read_en[p][l]) begin
              exp_rvalid[i][p][l] = !m_busy;
              if (int'(raddr[p]) >= dep[i])
                exp_rdata[i][p][l] = '0;
              else if (byp[i] && m_busy && int'(raddr[p]) == m_caddr)
                exp_rdata[i][p][l] = '0;
              else if (byp[i] && !m_busy && m_wok && write_en[l] && raddr[p] == waddr)
                exp_rdata[i][p][l] = wdata[l];
              else
                exp_rdata[i][p][l] = mmem[i][l][raddr[p]];
            end else begin
              exp_rvalid[i][p][l] = 1'b0;
            end
          end
        end
        exp_drop[i] = (write_en != 8'h00) && (m_busy || !m_wok);
        if (m_busy) begin
          for (int l = 0; l < 8; l++) mmem[i][l][m_caddr] = '0;
          left[i] = left[i] - 1;
        end else begin
          if (m_wok)
            for (int l = 0; l < 8; l++) if (write_en[l]) mmem[i][l][waddr] = wdata[l];
          if (clear_req) left[i] = dep[i];
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_live) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d_busy", i), 64'(busy_o[i]), 64'(left[i] > 0));
        chk($sformatf("u%0d_drop", i), 64'(drop_o[i]), 64'(exp_drop[i]));
        chk($sformatf("u%0d_rvalid", i), 64'(rvalid_o[i]), 64'(exp_rvalid[i]));
        for (int p = 0; p < 2; p++)
          for (int l = 0; l < 8; l++)
            chk($sformatf("u%0d_rdata_p%0d_l%0d", i, p, l), rdata_o[i][p][l], exp_rdata[i][p][l]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_in();
    clear_req = 1'b0;
    write_en  = '0;
    waddr     = '0;
    wdata     = '0;
    read_en   = '0;
    raddr     = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic write_all(input logic [3:0] a, input logic [63:0] base);
    write_en = 8'hFF;
    waddr    = a;
    for (int l = 0; l < 8; l++) wdata[l] = base + 64'(l);
  endtask

  task automatic read_both(input logic [3:0] a0, input logic [3:0] a1);
    read_en  = 16'hFFFF;
    raddr[0] = a0;
    raddr[1] = a1;
  endtask

  task automatic count_busy(input string name, input int start, input int want);
    int n;
    n = start;
    while (busy_o[0] && n < 64) begin
      tick();
      n++;
    end
    chk(name, 64'(n), 64'(want));
  endtask

  task automatic fill_all();
    for (int a = 0; a < 16; a++) begin
      idle_in();
      write_all(4'(a), 64'h1000 * 64'(a + 1));
      tick();
      if (a == 13) begin
        chk("d12_fill_drop13", 64'(drop_o[2]), 64'd1);
        chk("d16_fill_nodrop13", 64'(drop_o[0]), 64'd0);
      end
    end
    idle_in();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    idle_in();
    tick();
    tick();
    chk("reset_busy", 64'(busy_o[0]), 64'd1);
    chk("reset_rvalid", 64'(rvalid_o[0]), 64'd0);
    chk("reset_rdata", rdata_o[0][1][7], 64'd0);
    rst_n = 1'b1;
    count_busy("init_busy_edges", 0, 16);

    // all addresses read back zero on both ports
    for (int a = 0; a < 16; a++) begin
      read_both(4'(a), 4'(15 - a));
      tick();
    end
    chk("zero_rvalid", 64'(rvalid_o[0]), 64'hFFFF);
    chk("zero_rdata", rdata_o[0][0][3], 64'd0);
    idle_in();

    // write addr 3, read it on both ports next edge
    write_all(4'd3, 64'hA5A5_0000_0000_0000);
    tick();
    idle_in();
    read_both(4'd3, 4'd3);
    tick();
    for (int l = 0; l < 8; l++) begin
      chk($sformatf("a5_p0_l%0d", l), rdata_o[0][0][l], 64'hA5A5_0000_0000_0000 + 64'(l));
      chk($sformatf("a5_p1_l%0d", l), rdata_o[0][1][l], 64'hA5A5_0000_0000_0000 + 64'(l));
    end
    idle_in();

    // same-edge write and read of addr 7
    write_en = 8'hFF;
    waddr    = 4'd7;
    for (int l = 0; l < 8; l++) wdata[l] = 64'hDEAD_BEEF;
    read_en[0] = 8'hFF;
    raddr[0]   = 4'd7;
    tick();
    chk("bypass1_new", rdata_o[0][0][0], 64'hDEAD_BEEF);
    chk("bypass0_old", rdata_o[1][0][0], 64'd0);
    idle_in();

    // partial lane write and partial read
    write_all(4'd2, 64'hB000);
    tick();
    idle_in();
    write_en = 8'h0F;
    waddr    = 4'd2;
    for (int l = 0; l < 8; l++) wdata[l] = 64'hC000 + 64'(l);
    read_en[0] = 8'hFF;
    raddr[0]   = 4'd2;
    tick();
    idle_in();
    read_en[0] = 8'h0F;
    raddr[0]   = 4'd2;
    tick();
    chk("partial_rvalid", 64'(rvalid_o[0]), 64'h000F);
    chk("partial_new_l1", rdata_o[0][0][1], 64'hC001);
    chk("partial_held_l5", rdata_o[0][0][5], 64'hB005);
    chk("partial_old_bp0_l5", rdata_o[1][0][5], 64'hB005);
    idle_in();

    // fill everything, then clear with a write and a repeated request inside
    fill_all();
    clear_req  = 1'b1;
    read_en[0] = 8'hFF;
    raddr[0]   = 4'd5;
    tick();
    chk("pre_clear_addr5", rdata_o[0][0][0], 64'h6000);
    idle_in();
    clear_req  = 1'b1;
    write_all(4'd9, 64'hBAD0);
    read_en[1] = 8'hFF;
    raddr[1]   = 4'd15;
    tick();
    chk("clear_drop", 64'(drop_o[0]), 64'd1);
    chk("clear_rvalid0", 64'(rvalid_o[0]), 64'd0);
    chk("clear_read_data", rdata_o[0][1][2], 64'h10002);
    idle_in();
    count_busy("clear_busy_edges", 1, 16);
    for (int a = 0; a < 16; a++) begin
      read_both(4'(a), 4'(a));
      tick();
    end
    idle_in();
    read_both(4'd9, 4'd15);
    tick();
    chk("post_clear_a9", rdata_o[0][0][0], 64'd0);
    chk("post_clear_a15", rdata_o[1][1][6], 64'd0);
    idle_in();

    // reset in the middle of a clear walk restarts it
    fill_all();
    clear_req = 1'b1;
    tick();
    idle_in();
    for (int k = 0; k < 4; k++) tick();
    rst_n = 1'b0;
    tick();
    chk("midreset_busy", 64'(busy_o[0]), 64'd1);
    rst_n = 1'b1;
    count_busy("restart_busy_edges", 0, 16);
    for (int a = 0; a < 16; a++) begin
      read_both(4'(a), 4'(15 - a));
      tick();
    end
    idle_in();

    // out-of-range handling on the DEPTH=12 instance
    write_all(4'd13, 64'hFFFF_0000);
    tick();
    chk("d12_drop", 64'(drop_o[2]), 64'd1);
    chk("d16_nodrop", 64'(drop_o[0]), 64'd0);
    idle_in();
    read_both(4'd13, 4'd11);
    tick();
    chk("d12_oor_rdata", rdata_o[2][0][4], 64'd0);
    chk("d12_oor_rvalid", 64'(rvalid_o[2]), 64'hFFFF);
    chk("d16_a13", rdata_o[0][0][0], 64'hFFFF_0000);
    chk("d12_a11", rdata_o[2][1][0], 64'd0);
    idle_in();
    tick();
    chk("drop_pulse_end", 64'(drop_o[2]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
